// File: rtl/lfclk_pkg.sv
// Shared constants for the low-frequency clock tick counter.
//   SYNC_STAGES_DEF : default synchronizer depth on lfclk
//   CNT_W_DEF       : default tick counter / compare width
//   LOST_LIMIT_DEF  : default clk cycles without a tick before lfclk_lost
//   WD_W_DEF        : watchdog counter width for the default limit
//   wd_width()      : watchdog width for any limit (counts 0..limit inclusive)
package lfclk_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned LOST_LIMIT_DEF  = 1024;

  function automatic int unsigned wd_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  localparam int unsigned WD_W_DEF = $clog2(LOST_LIMIT_DEF + 1);

endpackage

// File: rtl/lfclk_tick_counter_if.sv
// Register-side bus of the tick counter.
//   master : drives cnt_en, cnt_clr, cmp_we, cmp_wdata, irq_clr;
//            observes tick, cnt, ovf, irq, lfclk_lost
//   slave  : the counter itself (opposite directions)
interface lfclk_tick_counter_if #(
  parameter int unsigned CNT_W = lfclk_pkg::CNT_W_DEF
);

  logic             cnt_en;
  logic             cnt_clr;
  logic             cmp_we;
  logic [CNT_W-1:0] cmp_wdata;
  logic             irq_clr;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             irq;
  logic             lfclk_lost;

  modport master (
    output cnt_en, cnt_clr, cmp_we, cmp_wdata, irq_clr,
    input  tick, cnt, ovf, irq, lfclk_lost
  );

  modport slave (
    input  cnt_en, cnt_clr, cmp_we, cmp_wdata, irq_clr,
    output tick, cnt, ovf, irq, lfclk_lost
  );

endinterface

// File: rtl/lfclk_sync.sv
// Multi-flop synchronizer for a single asynchronous level; all stages reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   i_d   : asynchronous input level
//   o_q   : synchronized level, STAGES clk edges behind i_d
module lfclk_sync
  import lfclk_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: flops use non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/lfclk_tick_counter.sv
// Brings the divided 32.768 kHz clock into the clk domain, emits one tick per
// lfclk rising edge, counts ticks, raises a sticky compare interrupt and flags
// a missing lfclk.
//   clk, rst_n : fast clock, asynchronous active-low reset
//   lfclk      : low-frequency clock, asynchronous to clk
//   bus        : slave side of lfclk_tick_counter_if
//                (cnt_en, cnt_clr, cmp_we, cmp_wdata, irq_clr in;
//                 tick, cnt, ovf, irq, lfclk_lost out)
module lfclk_tick_counter
  import lfclk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned LOST_LIMIT  = LOST_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lfclk,
  lfclk_tick_counter_if.slave  bus
);

  localparam int unsigned      WD_W      = wd_width(LOST_LIMIT);
  localparam int unsigned      FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(LOST_LIMIT);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);

  // ---------------------------------------------------------------------------
  // Synchronizer, arming and edge detect
  // ---------------------------------------------------------------------------
  logic w_s;

  lfclk_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (lfclk),
    .o_q   (w_s)
  );

  logic              r_prev;
  logic              r_armed;
  logic              r_tick;
  logic [FILL_W-1:0] r_fill;

  // The chain powers up as zeros, so a low w_s is only trusted once the chain
  // has been refilled with real lfclk samples (r_fill saturated). Otherwise an
  // lfclk held high across reset release would look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_tick  <= 1'b0;
      r_fill  <= '0;
    end else begin
      r_prev <= w_s;
      if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      if ((r_fill == FILL_FULL) && !w_s) begin
        r_armed <= 1'b1;
      end
      r_tick <= w_s & ~r_prev & r_armed;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick counter, overflow and compare interrupt
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cmp;
  logic             r_ovf;
  logic             r_irq;
  logic             w_inc;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_match;

  // Clear outranks increment, so a tick landing on a clear is dropped and can
  // never produce a match. The match uses the pre-edge r_cmp, so a compare
  // write in the same cycle only affects later increments.
  assign w_inc      = r_tick & bus.cnt_en & ~bus.cnt_clr;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_match    = w_inc && (w_cnt_next == r_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
      r_cmp <= '1;
    end else begin
      if (bus.cnt_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_inc) begin
        r_cnt <= w_cnt_next;
        if (w_cnt_next == '0) begin
          r_ovf <= 1'b1;
        end
      end

      // A new match wins over a simultaneous software clear.
      if (w_match) begin
        r_irq <= 1'b1;
      end else if (bus.irq_clr) begin
        r_irq <= 1'b0;
      end

      if (bus.cmp_we) begin
        r_cmp <= bus.cmp_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Missing-clock watchdog
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0] r_wd;
  logic            r_lost;

  // r_lost is updated together with r_wd so it always equals (r_wd == WD_MAX)
  // without a combinational compare on the output. It keeps running while
  // unarmed so a stuck-high lfclk after reset is still reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else if (r_tick) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else if (r_wd != WD_MAX) begin
      r_wd   <= r_wd + WD_W'(1);
      r_lost <= (r_wd == (WD_MAX - WD_W'(1)));
    end
  end

  assign bus.tick       = r_tick;
  assign bus.cnt        = r_cnt;
  assign bus.ovf        = r_ovf;
  assign bus.irq        = r_irq;
  assign bus.lfclk_lost = r_lost;

endmodule

// File: tb/tb_lfclk_tick_counter.sv
// Self-checking bench for lfclk_tick_counter. lfclk is driven synchronously on
// the falling clk edge so every rising clk edge takes a well-defined sample.
// The reference model works on the sampled lfclk history: a tick is expected
// SYNC edges after any real low-to-high pair of samples; counter, compare and
// watchdog follow from plain arithmetic on those ticks.
module tb_lfclk_tick_counter;
  import lfclk_pkg::*;

  localparam int SYNC  = 2;
  localparam int CW    = 8;
  localparam int LIMIT = 1024;
  localparam int CMAX  = 1 << CW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic lfclk = 1'b0;

  lfclk_tick_counter_if #(.CNT_W(CW)) bus ();

  lfclk_tick_counter #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW),
    .LOST_LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lfclk (lfclk),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  bit hist[$];   // hist[k-1] = lfclk sampled on edge k after reset release
  int n;         // edges since reset release
  bit m_tick;
  int m_cnt;
  bit m_ovf;
  bit m_irq;
  int m_cmp;
  int t_last;    // edge after which the latest tick was visible (-1 = reset)

  function automatic bit m_lost();
    return (n - t_last) >= (LIMIT + 1);
  endfunction

  function automatic bit lf_at(input int i, input int per);
    return (i % per) >= (per / 2);
  endfunction

  task automatic model_reset();
    hist.delete();
    n      = 0;
    m_tick = 1'b0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_cmp  = CMAX - 1;
    t_last = -1;
  endtask

  task automatic do_reset(input bit lf);
    rst_n         = 1'b0;
    lfclk         = lf;
    bus.cnt_en    = 1'b0;
    bus.cnt_clr   = 1'b0;
    bus.cmp_we    = 1'b0;
    bus.cmp_wdata = '0;
    bus.irq_clr   = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clk cycle: drive lfclk, advance the model on the rising edge, return
  // on the falling edge with single-cycle pulses released.
  task automatic step(input bit lf);
    bit prev;
    bit set;
    lfclk = lf;
    @(posedge clk);
    n++;
    hist.push_back(lf);
    prev   = m_tick;
    m_tick = 1'b0;
    if (n - SYNC - 1 >= 1) begin
      m_tick = hist[n-SYNC-1] && !hist[n-SYNC-2];
    end
    if (prev) t_last = n - 1;
    set = 1'b0;
    if (bus.cnt_clr) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (prev && bus.cnt_en) begin
      m_cnt = (m_cnt + 1) % CMAX;
      if (m_cnt == 0) m_ovf = 1'b1;
      if (m_cnt == m_cmp) set = 1'b1;
    end
    if (set) m_irq = 1'b1;
    else if (bus.irq_clr) m_irq = 1'b0;
    if (bus.cmp_we) m_cmp = int'(bus.cmp_wdata);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    bus.cmp_we  = 1'b0;
    bus.irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (bus.tick !== 1'b0) begin fails++; $display("FAIL reset.tick got %b want 0", bus.tick); end
    checks++; if (bus.cnt !== '0) begin fails++; $display("FAIL reset.cnt got %0d want 0", bus.cnt); end
    checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset.ovf got %b want 0", bus.ovf); end
    checks++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset.irq got %b want 0", bus.irq); end
    checks++; if (bus.lfclk_lost !== 1'b0) begin fails++; $display("FAIL reset.lost got %b want 0", bus.lfclk_lost); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      checks++; if (bus.tick !== m_tick || bus.cnt !== CW'(m_cnt)) begin fails++; $display("FAIL reset.idle @%0d tick %b cnt %0d want %b %0d", n, bus.tick, bus.cnt, m_tick, m_cnt); end
    end
  endtask

  task automatic test_basic();
    int  nt = 0, last = -1, gap_bad = 0, wide = 0;
    bit  prev_t = 1'b0, lost_seen = 1'b0;
    do_reset(1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 10 * 256; i++) begin
      step(lf_at(i, 256));
      checks++; if (bus.tick !== m_tick) begin fails++; $display("FAIL basic.tick @%0d got %b want %b", n, bus.tick, m_tick); end
      checks++; if (bus.cnt !== CW'(m_cnt)) begin fails++; $display("FAIL basic.cnt @%0d got %0d want %0d", n, bus.cnt, m_cnt); end
      checks++; if (bus.lfclk_lost !== m_lost()) begin fails++; $display("FAIL basic.lost @%0d got %b want %b", n, bus.lfclk_lost, m_lost()); end
      if (bus.tick === 1'b1) begin
        if (prev_t) wide++;
        else begin
          if (last >= 0 && n - last != 256) gap_bad++;
          last = n;
          nt++;
        end
      end
      prev_t = (bus.tick === 1'b1);
      if (bus.lfclk_lost === 1'b1) lost_seen = 1'b1;
    end
    checks++; if (nt != 10) begin fails++; $display("FAIL basic.tick_count got %0d want 10", nt); end
    checks++; if (wide != 0) begin fails++; $display("FAIL basic.tick_width got %0d wide pulses want 0", wide); end
    checks++; if (gap_bad != 0) begin fails++; $display("FAIL basic.tick_spacing got %0d bad gaps want 0", gap_bad); end
    checks++; if (bus.cnt !== CW'(10)) begin fails++; $display("FAIL basic.final_cnt got %0d want 10", bus.cnt); end
    checks++; if (lost_seen) begin fails++; $display("FAIL basic.lost_seen got 1 want 0"); end
  endtask

  task automatic test_arm_high();
    int e_rise = -1, e_tick = -1;
    bit early = 1'b0;
    do_reset(1'b1);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < LIMIT + 10; i++) begin
      step(1'b1);
      if (bus.tick === 1'b1) early = 1'b1;
      checks++; if (bus.lfclk_lost !== m_lost()) begin fails++; $display("FAIL arm.lost @%0d got %b want %b", n, bus.lfclk_lost, m_lost()); end
    end
    checks++; if (early) begin fails++; $display("FAIL arm.spurious_tick got 1 want 0"); end
    checks++; if (bus.lfclk_lost !== 1'b1) begin fails++; $display("FAIL arm.stuck_high_lost got %b want 1", bus.lfclk_lost); end
    for (int i = 0; i < 20; i++) begin
      step(i >= 5);
      if (i == 5) e_rise = n;
      if (bus.tick === 1'b1 && e_tick < 0) e_tick = n;
      checks++; if (bus.tick !== m_tick) begin fails++; $display("FAIL arm.tick @%0d got %b want %b", n, bus.tick, m_tick); end
      checks++; if (bus.lfclk_lost !== m_lost()) begin fails++; $display("FAIL arm.lost2 @%0d got %b want %b", n, bus.lfclk_lost, m_lost()); end
    end
    // Sampling edge counts as the first of SYNC+1 edges.
    checks++; if (e_tick != e_rise + SYNC) begin fails++; $display("FAIL arm.first_tick_edge got %0d want %0d", e_tick, e_rise + SYNC); end
  endtask

  task automatic test_compare();
    int stage = 0, chk;
    bit rise_done = 1'b0, prev_irq = 1'b0;
    do_reset(1'b0);
    bus.cnt_en    = 1'b1;
    bus.cmp_we    = 1'b1;
    bus.cmp_wdata = CW'(5);
    for (int i = 0; i < 800 && stage != 9; i++) begin
      chk = 0;
      case (stage)
        0: if (rise_done) begin bus.irq_clr = 1'b1; stage = 1; end
        1: begin bus.cnt_clr = 1'b1; stage = 2; end
        2: if (m_tick && m_cnt == 4) begin bus.irq_clr = 1'b1; chk = 1; stage = 3; end
        3: begin bus.irq_clr = 1'b1; stage = 4; end
        4: if (m_tick && m_cnt == 6) begin bus.cmp_we = 1'b1; bus.cmp_wdata = CW'(7); chk = 2; stage = 5; end
        5: begin bus.cnt_clr = 1'b1; stage = 6; end
        6: if (m_tick && m_cnt == 6) begin chk = 3; stage = 7; end
        7: begin bus.cmp_we = 1'b1; bus.cmp_wdata = '0; bus.irq_clr = 1'b1; stage = 8; end
        8: begin bus.cnt_clr = 1'b1; chk = 4; stage = 9; end
        default: ;
      endcase
      step(lf_at(i, 8));
      checks++; if (bus.cnt !== CW'(m_cnt)) begin fails++; $display("FAIL cmp.cnt @%0d got %0d want %0d", n, bus.cnt, m_cnt); end
      checks++; if (bus.irq !== m_irq) begin fails++; $display("FAIL cmp.irq @%0d got %b want %b", n, bus.irq, m_irq); end
      if (stage == 0 && !rise_done && bus.cnt === CW'(5)) begin
        rise_done = 1'b1;
        checks++; if (bus.irq !== 1'b1 || prev_irq !== 1'b0) begin fails++; $display("FAIL cmp.rise got irq %b prev %b want 1 0", bus.irq, prev_irq); end
      end
      case (chk)
        1: begin checks++; if (bus.irq !== 1'b1 || bus.cnt !== CW'(5)) begin fails++; $display("FAIL cmp.set_beats_clr got irq %b cnt %0d want 1 5", bus.irq, bus.cnt); end end
        2: begin checks++; if (bus.irq !== 1'b0 || bus.cnt !== CW'(7)) begin fails++; $display("FAIL cmp.old_cmp got irq %b cnt %0d want 0 7", bus.irq, bus.cnt); end end
        3: begin checks++; if (bus.irq !== 1'b1 || bus.cnt !== CW'(7)) begin fails++; $display("FAIL cmp.new_cmp got irq %b cnt %0d want 1 7", bus.irq, bus.cnt); end end
        4: begin checks++; if (bus.irq !== 1'b0 || bus.cnt !== '0) begin fails++; $display("FAIL cmp.clr_no_irq got irq %b cnt %0d want 0 0", bus.irq, bus.cnt); end end
        default: ;
      endcase
      prev_irq = bus.irq;
    end
    checks++; if (stage != 9) begin fails++; $display("FAIL cmp.timeout got stage %0d want 9", stage); end
  endtask

  task automatic test_wrap();
    int phase = 0;
    do_reset(1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 3000 && phase != 4; i++) begin
      if (phase == 2 && m_tick) begin bus.cnt_clr = 1'b1; phase = 3; end
      step(lf_at(i, 4));
      checks++; if (bus.cnt !== CW'(m_cnt) || bus.ovf !== m_ovf) begin fails++; $display("FAIL wrap.state @%0d got cnt %0d ovf %b want %0d %b", n, bus.cnt, bus.ovf, m_cnt, m_ovf); end
      checks++; if (bus.irq !== m_irq) begin fails++; $display("FAIL wrap.irq @%0d got %b want %b", n, bus.irq, m_irq); end
      if (phase == 0 && bus.cnt === CW'(CMAX - 1)) begin
        checks++; if (bus.irq !== 1'b1 || bus.ovf !== 1'b0) begin fails++; $display("FAIL wrap.all_ones got irq %b ovf %b want 1 0", bus.irq, bus.ovf); end
        phase = 1;
      end else if (phase == 1 && bus.cnt === '0) begin
        checks++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL wrap.ovf got %b want 1", bus.ovf); end
        phase = 2;
      end else if (phase == 3) begin
        checks++; if (bus.cnt !== '0 || bus.ovf !== 1'b0) begin fails++; $display("FAIL wrap.clr_with_tick got cnt %0d ovf %b want 0 0", bus.cnt, bus.ovf); end
        phase = 4;
      end
    end
    checks++; if (phase != 4) begin fails++; $display("FAIL wrap.timeout got phase %0d want 4", phase); end
  endtask

  task automatic test_lost();
    int  last_tick = -1, rise = -1, drops = 0;
    bit  pend = 1'b0;
    do_reset(1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 100 + 1100; i++) begin
      step(i < 100 ? lf_at(i, 16) : 1'b0);
      if (bus.tick === 1'b1) last_tick = n;
      if (bus.lfclk_lost === 1'b1 && rise < 0) rise = n;
      checks++; if (bus.lfclk_lost !== m_lost()) begin fails++; $display("FAIL lost.hold @%0d got %b want %b", n, bus.lfclk_lost, m_lost()); end
    end
    checks++; if (rise - last_tick != LIMIT + 1) begin fails++; $display("FAIL lost.rise_delay got %0d want %0d", rise - last_tick, LIMIT + 1); end
    for (int i = 0; i < 64; i++) begin
      step(lf_at(i, 16));
      if (pend) begin
        drops++;
        checks++; if (bus.lfclk_lost !== 1'b0) begin fails++; $display("FAIL lost.drop @%0d got %b want 0", n, bus.lfclk_lost); end
      end
      pend = (bus.tick === 1'b1) && (bus.lfclk_lost === 1'b1);
      checks++; if (bus.lfclk_lost !== m_lost() || bus.tick !== m_tick) begin fails++; $display("FAIL lost.resume @%0d got lost %b tick %b want %b %b", n, bus.lfclk_lost, bus.tick, m_lost(), m_tick); end
    end
    checks++; if (drops != 1) begin fails++; $display("FAIL lost.drop_seen got %0d want 1", drops); end
  endtask

  task automatic test_random();
    int per = 16;
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) per = $urandom_range(4, 60);
      bus.cnt_en  = ($urandom_range(0, 7) != 0);
      bus.cnt_clr = ($urandom_range(0, 49) == 0);
      bus.irq_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.cmp_we    = 1'b1;
        bus.cmp_wdata = CW'($urandom_range(0, 15));
      end
      step(lf_at(i, per));
      checks++; if (bus.tick !== m_tick) begin fails++; $display("FAIL rand.tick @%0d got %b want %b", n, bus.tick, m_tick); end
      checks++; if (bus.cnt !== CW'(m_cnt) || bus.ovf !== m_ovf) begin fails++; $display("FAIL rand.cnt @%0d got %0d/%b want %0d/%b", n, bus.cnt, bus.ovf, m_cnt, m_ovf); end
      checks++; if (bus.irq !== m_irq) begin fails++; $display("FAIL rand.irq @%0d got %b want %b", n, bus.irq, m_irq); end
      checks++; if (bus.lfclk_lost !== m_lost()) begin fails++; $display("FAIL rand.lost @%0d got %b want %b", n, bus.lfclk_lost, m_lost()); end
    end
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    do_reset(1'b0);
    bus.cnt_en    = 1'b1;
    bus.cmp_we    = 1'b1;
    bus.cmp_wdata = CW'(20);
    for (int i = 0; i < 400 && m_cnt != 37; i++) begin
      step(lf_at(i, 4));
      checks++; if (bus.cnt !== CW'(m_cnt) || bus.irq !== m_irq) begin fails++; $display("FAIL arst.pre @%0d got cnt %0d irq %b want %0d %b", n, bus.cnt, bus.irq, m_cnt, m_irq); end
    end
    checks++; if (bus.cnt !== CW'(37) || bus.irq !== 1'b1) begin fails++; $display("FAIL arst.setup got cnt %0d irq %b want 37 1", bus.cnt, bus.irq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.tick, bus.ovf, bus.irq, bus.lfclk_lost} !== 4'b0000 || bus.cnt !== '0) begin fails++; $display("FAIL arst.immediate got tick %b cnt %0d ovf %b irq %b lost %b want all 0", bus.tick, bus.cnt, bus.ovf, bus.irq, bus.lfclk_lost); end
    do_reset(1'b0);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 1200 && !hit; i++) begin
      step(lf_at(i, 4));
      checks++; if (bus.irq !== m_irq || bus.cnt !== CW'(m_cnt)) begin fails++; $display("FAIL arst.post @%0d got irq %b cnt %0d want %b %0d", n, bus.irq, bus.cnt, m_irq, m_cnt); end
      if (bus.cnt === CW'(CMAX - 1)) begin
        hit = 1'b1;
        checks++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL arst.cmp_all_ones got irq %b want 1", bus.irq); end
      end
    end
    checks++; if (!hit) begin fails++; $display("FAIL arst.timeout got no all-ones count want one"); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got no end of test want completion");
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    test_reset();
    test_basic();
    test_arm_high();
    test_compare();
    test_wrap();
    test_lost();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
